// File: rtl/relay_seq_pkg.sv
// Shared types and helpers for the break-before-make relay sequencer.
package relay_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BREAK,
      MAKE,
      SETTLE,
      DONE
   } seq_state_t;

   localparam int HOLD_PHASE_W = 4;

   function automatic int cw(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/relay_bbm_sequencer_dwell_timer.sv
// Down-counting dwell timer. A load takes priority over a decrement.
// zero is a decode of the registered count, so it is valid on the cycle after a load.
module dwell_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/relay_bbm_sequencer.sv
// Break-before-make coil sequencer: change of channel takes BREAK_CYC+SETTLE_CYC+2 clocks, open-all BREAK_CYC+1, same channel 1.
// Backpressure: req_ready is high only in IDLE; requests are not queued. RELAY_SEQ_HOLD_EN enables PWM hold of the settled coil.
module relay_bbm_sequencer
   import relay_seq_pkg::*;
#(
   parameter int N_CHAN     = 4,
   parameter int BREAK_CYC  = 8,
   parameter int SETTLE_CYC = 20,
   parameter int HOLD_DUTY  = 8,
   localparam int CW        = cw(N_CHAN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CW-1:0]     req_chan,
   input  logic              req_off,
   output logic [N_CHAN-1:0] coil_en,
   output logic [CW-1:0]     active_chan,
   output logic              active_vld,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int TW = $clog2((BREAK_CYC > SETTLE_CYC) ? BREAK_CYC : SETTLE_CYC) + 1;
   localparam logic [TW-1:0] BREAK_LD  = TW'(BREAK_CYC - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

   seq_state_t    state_q, state_d;
   logic [CW-1:0] chan_q, chan_d;
   logic [CW-1:0] active_chan_q, active_chan_d;
   logic          off_q, off_d;
   logic          active_vld_q, active_vld_d;
   logic          err_q, err_d;

   logic          tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0] tmr_load_val, tmr_count;
   logic          accept, in_range, same_chan, hold_on;

   assign accept    = req_valid && (state_q == IDLE);
   assign in_range  = ({1'b0, req_chan} < (CW + 1)'(N_CHAN));
   assign same_chan = !req_off && active_vld_q && (req_chan == active_chan_q);

   // One timer serves both dwell phases; each phase reloads it on entry.
   dwell_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         chan_q        <= '0;
         off_q         <= 1'b0;
         active_chan_q <= '0;
         active_vld_q  <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         chan_q        <= chan_d;
         off_q         <= off_d;
         active_chan_q <= active_chan_d;
         active_vld_q  <= active_vld_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      chan_d        = chan_q;
      off_d         = off_q;
      active_chan_d = active_chan_q;
      active_vld_d  = active_vld_q;
      err_d         = accept && !in_range;
      tmr_load      = 1'b0;
      tmr_load_val  = BREAK_LD;
      tmr_en        = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && in_range) begin
               if (same_chan) begin
                  state_d = DONE;
               end else begin
                  state_d      = BREAK;
                  chan_d       = req_chan;
                  off_d        = req_off;
                  active_vld_d = 1'b0;
                  tmr_load     = 1'b1;
                  tmr_load_val = BREAK_LD;
               end
            end
         end
         BREAK: begin
            tmr_en = (tmr_count != '0);
            if (tmr_zero) begin
               state_d = off_q ? DONE : MAKE;
            end
         end
         MAKE: begin
            state_d      = SETTLE;
            tmr_load     = 1'b1;
            tmr_load_val = SETTLE_LD;
         end
         SETTLE: begin
            tmr_en = (tmr_count != '0);
            if (tmr_zero) begin
               state_d       = DONE;
               active_chan_d = chan_q;
               active_vld_d  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef RELAY_SEQ_HOLD_EN
   logic [HOLD_PHASE_W-1:0] phase_q, phase_d;

   assign phase_d = phase_q + HOLD_PHASE_W'(1);
   assign hold_on = ({1'b0, phase_q} < (HOLD_PHASE_W + 1)'(HOLD_DUTY));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end
`else
   assign hold_on = 1'b1;
`endif

   // Only the settled coil is economised; MAKE, SETTLE and DONE drive it fully.
   always_comb begin
      coil_en = '0;
      case (state_q)
         MAKE, SETTLE: coil_en = N_CHAN'(1) << chan_q;
         DONE:         if (active_vld_q) coil_en = N_CHAN'(1) << active_chan_q;
         IDLE:         if (active_vld_q && hold_on) coil_en = N_CHAN'(1) << active_chan_q;
         default:      coil_en = '0;
      endcase
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign err         = err_q;
   assign active_chan = active_chan_q;
   assign active_vld  = active_vld_q;

endmodule

// File: tb/tb_relay_bbm_sequencer.sv
// Bench for relay_bbm_sequencer: directed and random requests against a cycle-count schedule model.
module tb_relay_bbm_sequencer;

   localparam int N  = 4;
   localparam int B  = 8;
   localparam int S  = 20;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req_valid, req_off, req_ready, active_vld, busy, done, err;
   logic [CW-1:0] req_chan, active_chan;
   logic [N-1:0]  coil_en;

   logic          r2_valid, r2_off, r2_ready, a2_vld, b2, d2, e2;
   logic [2:0]    r2_chan, a2_chan;
   logic [5:0]    coil2;

   int errors = 0;
   int checks = 0;
   bit m_vld  = 1'b0;
   int m_chan = 0;

   relay_bbm_sequencer #(.N_CHAN(N), .BREAK_CYC(B), .SETTLE_CYC(S), .HOLD_DUTY(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_chan(req_chan), .req_off(req_off), .coil_en(coil_en), .active_chan(active_chan),
      .active_vld(active_vld), .busy(busy), .done(done), .err(err)
   );

   // Six channels so that unrepresentable-in-range codes 6 and 7 exist.
   relay_bbm_sequencer #(.N_CHAN(6), .BREAK_CYC(2), .SETTLE_CYC(3), .HOLD_DUTY(8)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(r2_ready),
      .req_chan(r2_chan), .req_off(r2_off), .coil_en(coil2), .active_chan(a2_chan),
      .active_vld(a2_vld), .busy(b2), .done(d2), .err(e2)
   );

   function automatic logic [N-1:0] oh(input int c);
      logic [N-1:0] one;
      one = 1;
      return one << c;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Break-before-make watchdog: one-hot-or-zero always, and no rise within B clocks of a fall.
   logic [N-1:0] prev_coil = '0;
   int since_drop = 1000;
   always @(negedge clk) begin
      checks++;
      assert ($onehot0(coil_en)) else begin
         errors++;
         $error("FAIL onehot0: observed=%b expected one-hot-or-zero", coil_en);
      end
      if ((prev_coil & ~coil_en) != '0) since_drop = 0;
      else if (since_drop < 1000) since_drop++;
`ifndef RELAY_SEQ_HOLD_EN
      if ((coil_en & ~prev_coil) != '0) begin
         checks++;
         assert (since_drop >= B) else begin
            errors++;
            $error("FAIL break_gap: observed=%0d expected>=%0d", since_drop, B);
         end
      end
`endif
      prev_coil = coil_en;
   end

   // Issues one request from a negedge; expected trace is derived from the schedule lengths.
   task automatic do_req(input int ch, input bit off);
      int len;
      bit same;
      logic [N-1:0] exp_coil;
      same = !off && m_vld && (ch == m_chan);
      len  = same ? 1 : (off ? B + 1 : B + S + 2);
      check("req_ready_pre", req_ready, 1);
      req_valid = 1'b1;
      req_chan  = CW'(ch);
      req_off   = off;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_chan  = CW'($urandom);
      req_off   = 1'($urandom);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (same) exp_coil = oh(m_chan);
         else if (off || k <= B) exp_coil = '0;
         else exp_coil = oh(ch);
         check("coil_en", coil_en, exp_coil);
         check("done", done, (k == len));
         if (k == 1 && !same) check("busy", busy, 1);
      end
      if (!same) begin
         m_vld = !off;
         if (!off) m_chan = ch;
      end
      @(negedge clk);
      check("done_end", done, 0);
      check("ready_end", req_ready, 1);
      check("busy_end", busy, 0);
      check("active_vld", active_vld, m_vld);
      if (m_vld) check("active_chan", active_chan, m_chan);
      check("coil_idle", coil_en, m_vld ? oh(m_chan) : '0);
   endtask

   initial begin
      int ch;
      bit seen_done;
      req_valid = 1'($urandom);
      req_chan  = CW'($urandom);
      req_off   = 1'($urandom);
      r2_valid  = 1'b0;
      r2_chan   = '0;
      r2_off    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_coil", coil_en, 0);
      check("rst_ready", req_ready, 1);
      check("rst_vld", active_vld, 0);
      check("rst_chan", active_chan, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      req_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      do_req(2, 1'b0);  // close from idle: coil at k=9, done at k=30
      do_req(1, 1'b0);  // switch 2->1
      do_req(1, 1'b0);  // same channel: done next clock
      do_req(0, 1'b1);  // open all: done at k=9

      // Out-of-range channel on the six-channel instance, after closing ch5 there.
      r2_valid = 1'b1; r2_chan = 3'd5; r2_off = 1'b0;
      @(posedge clk); #1; r2_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("d6_done_early", d2, 0);
      @(negedge clk);
      check("d6_done", d2, 1);
      check("d6_coil", coil2, 6'b100000);
      @(negedge clk);
      check("d6_vld", a2_vld, 1);
      check("d6_chan", a2_chan, 5);
      r2_valid = 1'b1; r2_chan = 3'd7;
      @(posedge clk); #1; r2_valid = 1'b0;
      @(negedge clk);
      check("d6_err", e2, 1);
      check("d6_err_busy", b2, 0);
      check("d6_err_done", d2, 0);
      check("d6_err_coil", coil2, 6'b100000);
      @(negedge clk);
      check("d6_err_pulse", e2, 0);
      check("d6_err_chan", a2_chan, 5);
      check("d6_err_vld", a2_vld, 1);

      repeat (25) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_req($urandom_range(0, N - 1), ($urandom_range(0, 4) == 0));
      end

      // Reset while SETTLE is holding the coil.
      ch = (m_vld && m_chan == 3) ? 2 : 3;
      req_valid = 1'b1; req_chan = CW'(ch); req_off = 1'b0;
      @(posedge clk); #1; req_valid = 1'b0;
      repeat (B + 5) @(posedge clk);
      #2;
      check("pre_rst_coil", coil_en, oh(ch));
      rst_n = 1'b0;
      #1;
      check("async_coil", coil_en, 0);
      check("async_vld", active_vld, 0);
      check("async_busy", busy, 0);
      m_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("no_done_after_rst", seen_done, 0);
      check("coil_after_rst", coil_en, 0);
      do_req(1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
